tdm_mux8: RTL and testbench

- 8-channel to 1-lane time-division multiplexer; the collecting counterpart of the 1x8 demultiplexer.
- Accepts words on eight independent input channels and holds one word per channel.
- Emits held words one per transfer on a single output lane, tagged with the 3-bit channel code, in round-robin order.
- Sits upstream of a 1x8 demux, which uses the tag as its select to route each word back to its lane.

---
 rtl/tdm_mux8.sv | 78 +++++++
 tb/tb_tdm_mux8.sv | 133 +++++++++++++
 2 files changed

// File: rtl/tdm_mux8.sv
// rtl/tdm_mux8.sv - 8-channel to 1-lane round-robin time-division multiplexer
module tdm_mux8 #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [8*WIDTH-1:0] in_data,
  input  logic [7:0]         in_valid,
  output logic [7:0]         in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [2:0]         out_sel,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [7:0]         frame_cnt
);

  logic [WIDTH-1:0] slot [8];
  logic [7:0]       pending;
  logic [7:0]       capture;
  logic [2:0]       last_sel;
  logic [2:0]       pick;
  logic             load_en;
  logic             xfer;

  assign in_ready = ~pending;
  assign capture  = in_valid & ~pending;
  assign load_en  = (~out_valid | out_ready) & (pending != 8'h00);
  assign xfer     = out_valid & out_ready;

  // Scan from the farthest offset down so the nearest pending channel after last_sel wins.
  always_comb begin
    pick = last_sel;
    for (int off = 8; off >= 1; off--) begin
      if (pending[last_sel + 3'(off)]) begin
        pick = last_sel + 3'(off);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (capture[i]) begin
        slot[i] <= in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending   <= 8'h00;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= 3'd0;
      last_sel  <= 3'd7;
      frame_cnt <= 8'h00;
    end else begin
      // A slot being selected is pending, so it cannot also be capturing this edge.
      for (int i = 0; i < 8; i++) begin
        if (capture[i]) begin
          pending[i] <= 1'b1;
        end
      end
      if (load_en) begin
        pending[pick] <= 1'b0;
        out_data      <= slot[pick];
        out_sel       <= pick;
        out_valid     <= 1'b1;
        last_sel      <= pick;
      end else if (xfer) begin
        out_valid <= 1'b0;
      end
      if (xfer) begin
        frame_cnt <= frame_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_tdm_mux8.sv
// tb/tb_tdm_mux8.sv - directed vector bench for tdm_mux8
module tb_tdm_mux8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] in_data = '0;
  logic [7:0]  in_valid = '0;
  logic [7:0]  in_ready;
  logic [7:0]  out_data;
  logic [2:0]  out_sel;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  frame_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  tdm_mux8 #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_sel(out_sel),
    .out_valid(out_valid), .out_ready(out_ready), .frame_cnt(frame_cnt)
  );

  typedef struct {
    logic        rst;
    logic [7:0]  iv;
    logic [63:0] d;
    logic        ordy;
    logic        ov;
    logic [2:0]  sel;
    logic [7:0]  od;
    logic [7:0]  rdy;
    logic [7:0]  fc;
  } vec_t;

  vec_t vecs[17];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_all(input string name, input logic ov, input logic [2:0] sel,
                            input logic [7:0] od, input logic [7:0] rdy, input logic [7:0] fc);
    chk({name, ".out_valid"}, {7'd0, out_valid}, {7'd0, ov});
    chk({name, ".out_sel"},   {5'd0, out_sel},   {5'd0, sel});
    chk({name, ".out_data"},  out_data,          od);
    chk({name, ".in_ready"},  in_ready,          rdy);
    chk({name, ".frame_cnt"}, frame_cnt,         fc);
  endtask

  task automatic drive(input logic r, input logic [7:0] iv, input logic [63:0] d, input logic ordy);
    rst = r; in_valid = iv; in_data = d; out_ready = ordy;
  endtask

  initial begin
    // Reset with all channels offering, release, then a single word on channel 5.
    vecs[0] = '{1'b1, 8'hFF, {8{8'h55}}, 1'b0, 1'b0, 3'd0, 8'h00, 8'hFF, 8'd0};
    vecs[1] = '{1'b1, 8'hFF, {8{8'h55}}, 1'b0, 1'b0, 3'd0, 8'h00, 8'hFF, 8'd0};
    vecs[2] = '{1'b0, 8'h00, 64'h0, 1'b1, 1'b0, 3'd0, 8'h00, 8'hFF, 8'd0};
    vecs[3] = '{1'b0, 8'h20, 64'h0000_A500_0000_0000, 1'b1, 1'b0, 3'd0, 8'h00, 8'hDF, 8'd0};
    vecs[4] = '{1'b0, 8'h00, 64'h0, 1'b1, 1'b1, 3'd5, 8'hA5, 8'hFF, 8'd0};
    vecs[5] = '{1'b0, 8'h00, 64'h0, 1'b1, 1'b0, 3'd5, 8'hA5, 8'hFF, 8'd1};
    // Re-reset so the sweep starts from channel 0, then load all eight slots.
    vecs[6] = '{1'b1, 8'h00, 64'h0, 1'b1, 1'b0, 3'd0, 8'h00, 8'hFF, 8'd0};
    vecs[7] = '{1'b0, 8'hFF, 64'h1716_1514_1312_1110, 1'b1, 1'b0, 3'd0, 8'h00, 8'h00, 8'd0};
    for (int k = 0; k < 8; k++) begin
      vecs[8+k] = '{1'b0, 8'h00, 64'h0, 1'b1, 1'b1, 3'(k), 8'(8'h10 + k),
                    8'((9'd1 << (k + 1)) - 9'd1), 8'(k)};
    end
    vecs[16] = '{1'b0, 8'h00, 64'h0, 1'b1, 1'b0, 3'd7, 8'h17, 8'hFF, 8'd8};

    for (int j = 0; j < 17; j++) begin
      drive(vecs[j].rst, vecs[j].iv, vecs[j].d, vecs[j].ordy);
      tick();
      expect_all($sformatf("vec%0d", j), vecs[j].ov, vecs[j].sel, vecs[j].od, vecs[j].rdy, vecs[j].fc);
    end

    // Back-pressure: channels 1,4,6 pending with output stalled; channel 1 refills during the stall.
    drive(1'b0, 8'h52, 64'h00A6_00A4_0000_A100, 1'b0);
    tick(); expect_all("bp_cap", 1'b0, 3'd7, 8'h17, 8'hAD, 8'd8);
    drive(1'b0, 8'h02, 64'h0000_0000_0000_B100, 1'b0);
    tick(); expect_all("bp_load", 1'b1, 3'd1, 8'hA1, 8'hAF, 8'd8);
    tick(); expect_all("bp_refill", 1'b1, 3'd1, 8'hA1, 8'hAD, 8'd8);
    drive(1'b0, 8'h00, 64'h0, 1'b0);
    for (int s = 0; s < 4; s++) begin
      tick(); expect_all($sformatf("bp_stall%0d", s), 1'b1, 3'd1, 8'hA1, 8'hAD, 8'd8);
    end
    drive(1'b0, 8'h00, 64'h0, 1'b1);
    tick(); expect_all("bp_rel4", 1'b1, 3'd4, 8'hA4, 8'hBD, 8'd9);
    tick(); expect_all("bp_rel6", 1'b1, 3'd6, 8'hA6, 8'hFD, 8'd10);
    tick(); expect_all("bp_rel1", 1'b1, 3'd1, 8'hB1, 8'hFF, 8'd11);
    tick(); expect_all("bp_empty", 1'b0, 3'd1, 8'hB1, 8'hFF, 8'd12);

    // Wrap: last_sel=6 with channels 0 and 7 pending while channel 0 keeps offering.
    drive(1'b0, 8'h40, 64'h00C6_0000_0000_0000, 1'b1);
    tick(); expect_all("wr_cap6", 1'b0, 3'd1, 8'hB1, 8'hBF, 8'd12);
    drive(1'b0, 8'h81, 64'hD700_0000_0000_00D0, 1'b1);
    tick(); expect_all("wr_sel6", 1'b1, 3'd6, 8'hC6, 8'h7E, 8'd12);
    drive(1'b0, 8'h01, 64'h0000_0000_0000_00E0, 1'b1);
    tick(); expect_all("wr_sel7", 1'b1, 3'd7, 8'hD7, 8'hFE, 8'd13);
    tick(); expect_all("wr_sel0", 1'b1, 3'd0, 8'hD0, 8'hFF, 8'd14);
    drive(1'b0, 8'h01, 64'h0000_0000_0000_00F0, 1'b1);
    tick(); expect_all("wr_refill", 1'b0, 3'd0, 8'hD0, 8'hFE, 8'd15);
    drive(1'b0, 8'h00, 64'h0, 1'b0);
    tick(); expect_all("wr_sel0b", 1'b1, 3'd0, 8'hF0, 8'hFF, 8'd15);

    // Reset while stalled with four slots pending.
    drive(1'b0, 8'h1E, {8{8'h77}}, 1'b0);
    tick(); expect_all("rm_fill", 1'b1, 3'd0, 8'hF0, 8'hE1, 8'd15);
    drive(1'b1, 8'h00, 64'h0, 1'b0);
    tick(); expect_all("rm_rst", 1'b0, 3'd0, 8'h00, 8'hFF, 8'd0);
    drive(1'b0, 8'h08, 64'h0000_0000_3300_0000, 1'b1);
    tick(); expect_all("rm_cap3", 1'b0, 3'd0, 8'h00, 8'hF7, 8'd0);
    drive(1'b0, 8'h00, 64'h0, 1'b1);
    tick(); expect_all("rm_out3", 1'b1, 3'd3, 8'h33, 8'hFF, 8'd0);
    tick(); expect_all("rm_done", 1'b0, 3'd3, 8'h33, 8'hFF, 8'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
